// File: rtl/board_console_ctrl_if.sv
// board_console_ctrl_if: register-file bus between the console and the multi-port regfile
interface board_console_ctrl_if #(
  parameter int ADDR = 5,
  parameter int SIZE = 32
);
  logic [ADDR-1:0] R_Addr_A, R_Addr_B, R_Addr_C, W_Addr;
  logic [SIZE-1:0] R_Data_A, R_Data_B, R_Data_C, W_Data;
  logic            Write_Reg, Clr_Reg;
  modport master (
    output R_Addr_A, R_Addr_B, R_Addr_C, W_Addr, W_Data, Write_Reg, Clr_Reg,
    input  R_Data_A, R_Data_B, R_Data_C
  );
  modport slave (
    input  R_Addr_A, R_Addr_B, R_Addr_C, W_Addr, W_Data, Write_Reg, Clr_Reg,
    output R_Data_A, R_Data_B, R_Data_C
  );
endinterface

// File: rtl/board_console_ctrl.sv
// board_console_ctrl: debounced switch/button console driving regfile entry and display view
module board_console_ctrl #(
  parameter int SW_W      = 32,
  parameter int ADDR      = 5,
  parameter int SIZE      = 32,
  parameter int DB_CYCLES = 16,
  parameter int NUM_VIEWS = 5
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [SW_W-1:0]      sw,
  input  logic                 btn_step,
  input  logic                 btn_arm,
  input  logic                 btn_clr,
  input  logic                 btn_disp,
  board_console_ctrl_if.master rf,
  output logic [2:0]           disp_sel,
  output logic [SIZE-1:0]      disp_data,
  output logic [1:0]           phase
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef enum logic [1:0] {S_ADDR = 2'd0, S_DATA = 2'd1, S_COMMIT = 2'd2} state_t;
  state_t          st, nxt;
  logic [3:0]      raw, s1, s2, lvl, lvl_d, pulse;
  logic [CW-1:0]   cnt [4];
  logic            step, arm, clr, disp, we;
  logic [SIZE-1:0] view;
  logic            unused_ok;
  assign raw       = {btn_disp, btn_clr, btn_arm, btn_step};
  assign step      = pulse[0];
  assign arm       = lvl[1];
  assign clr       = pulse[2];
  assign disp      = pulse[3];
  assign unused_ok = ^{sw, pulse[1]};
  // two-flop synchroniser and registered rising-edge pulse of each filtered level
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      s1    <= '0;
      s2    <= '0;
      lvl_d <= '0;
      pulse <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      pulse <= lvl & ~lvl_d;
    end
  // filtered level follows the synced input only after DB_CYCLES consecutive differing cycles
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      lvl <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // entry FSM state register
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) st <= S_ADDR;
    else st <= nxt;
  // next state: clear beats step; losing arm mid-entry abandons the write
  always_comb
    nxt = clr              ? S_ADDR :
          (st == S_ADDR)   ? ((step && arm) ? S_DATA : S_ADDR) :
          (st == S_DATA)   ? (!arm ? S_ADDR : step ? (we ? S_COMMIT : S_ADDR) : S_DATA) :
          S_ADDR;
  // strobes and LED phase decoded from state and pulses
  always_comb begin
    rf.Write_Reg = (st == S_COMMIT);
    rf.Clr_Reg   = clr;
    phase        = st;
  end
  // address/data latches, loaded on an armed step that is not overridden by clear
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      rf.R_Addr_A <= '0;
      rf.R_Addr_B <= '0;
      rf.R_Addr_C <= '0;
      rf.W_Addr   <= '0;
      rf.W_Data   <= '0;
      we          <= 1'b0;
    end else if (step && arm && !clr) begin
      if (st == S_ADDR) begin
        rf.R_Addr_A <= sw[ADDR-1:0];
        rf.R_Addr_B <= sw[2*ADDR-1:ADDR];
        rf.R_Addr_C <= sw[3*ADDR-1:2*ADDR];
        rf.W_Addr   <= sw[4*ADDR-1:3*ADDR];
        we          <= sw[SW_W-1];
      end
      if (st == S_DATA) rf.W_Data <= sw[SIZE-1:0];
    end
  // view multiplexer for the display driver
  always_comb
    view = (disp_sel == 3'd0) ? rf.R_Data_A :
           (disp_sel == 3'd1) ? rf.R_Data_B :
           (disp_sel == 3'd2) ? rf.R_Data_C :
           (disp_sel == 3'd3) ? rf.W_Data : '0;
  // view selector cycles on each disp press; display data registered one cycle behind
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      disp_sel  <= '0;
      disp_data <= '0;
    end else begin
      if (disp) disp_sel <= (disp_sel == 3'(NUM_VIEWS - 1)) ? 3'd0 : disp_sel + 3'd1;
      disp_data <= view;
    end
endmodule

// File: tb/tb_board_console_ctrl.sv
// tb_board_console_ctrl: directed checks of entry FSM, debounce timing, display and reset
module tb_board_console_ctrl;
  localparam logic [31:0] RDA = 32'h1111_AAAA, RDB = 32'h2222_BBBB, RDC = 32'h3333_CCCC;
  logic        clk = 1'b0, clr_n = 1'b0;
  logic [31:0] sw = '0;
  logic [3:0]  btn = '0;
  logic [2:0]  disp_sel;
  logic [31:0] disp_data;
  logic [1:0]  phase;
  int          n_chk = 0, n_pass = 0, wr_cnt = 0, clr_cnt = 0;
  board_console_ctrl_if #(.ADDR(5), .SIZE(32)) rf ();
  assign rf.R_Data_A = RDA;
  assign rf.R_Data_B = RDB;
  assign rf.R_Data_C = RDC;
  board_console_ctrl #(.SW_W(32), .ADDR(5), .SIZE(32), .DB_CYCLES(4), .NUM_VIEWS(5)) dut (
    .clk(clk), .clr_n(clr_n), .sw(sw),
    .btn_step(btn[0]), .btn_arm(btn[1]), .btn_clr(btn[2]), .btn_disp(btn[3]),
    .rf(rf.master), .disp_sel(disp_sel), .disp_data(disp_data), .phase(phase)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (clr_n && rf.Write_Reg) wr_cnt <= wr_cnt + 1;
    if (clr_n && rf.Clr_Reg) clr_cnt <= clr_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input int b);
    btn[b] = 1'b1;
    tick(10);
    btn[b] = 1'b0;
    tick(10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int k;
    tick(3);
    chk("rst_phase", phase, 0);
    chk("rst_wr", rf.Write_Reg, 0);
    chk("rst_addr", {rf.R_Addr_A, rf.R_Addr_B, rf.R_Addr_C, rf.W_Addr}, 0);
    chk("rst_wdata", rf.W_Data, 0);
    chk("rst_disp", {disp_sel, disp_data[28:0]}, 0);
    clr_n = 1'b1;
    btn[1] = 1'b1;
    tick(10);
    sw = 32'h8002_0C41;
    press(0);
    chk("t1_addr_a", rf.R_Addr_A, 1);
    chk("t1_addr_b", rf.R_Addr_B, 2);
    chk("t1_addr_c", rf.R_Addr_C, 3);
    chk("t1_waddr", rf.W_Addr, 4);
    chk("t1_phase", phase, 1);
    sw = 32'hDEAD_BEEF;
    btn[0] = 1'b1;
    k = 0;
    do begin tick(1); k++; end while (!rf.Write_Reg && k < 30);
    chk("t1_wr_lat", k, 8);
    chk("t1_wdata", rf.W_Data, 32'hDEAD_BEEF);
    tick(1);
    chk("t1_wr_one", rf.Write_Reg, 0);
    chk("t1_phase0", phase, 0);
    tick(9);
    btn[0] = 1'b0;
    tick(10);
    chk("t1_wr_cnt", wr_cnt, 1);
    sw = 32'h0002_0C45;
    press(0);
    chk("t2_phase1", phase, 1);
    chk("t2_addr_a", rf.R_Addr_A, 5);
    sw = 32'h1234_5678;
    press(0);
    chk("t2_wdata", rf.W_Data, 32'h1234_5678);
    chk("t2_phase0", phase, 0);
    chk("t2_no_wr", wr_cnt, 1);
    sw = 32'h0000_0000;
    btn[0] = 1'b1; tick(2);
    btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1;
    k = 0;
    do begin tick(1); k++; end while (phase != 2'd1 && k < 30);
    chk("t3_latency", k, 8);
    tick(2);
    btn[0] = 1'b0;
    tick(10);
    chk("t3_one_pulse", phase, 1);
    chk("t3_addr_a", rf.R_Addr_A, 0);
    sw = 32'h0BAD_F00D;
    press(0);
    chk("t3_phase0", phase, 0);
    chk("t3_wdata", rf.W_Data, 32'h0BAD_F00D);
    press(3); chk("t4_sel1", disp_sel, 1); chk("t4_dat1", disp_data, RDB);
    press(3); chk("t4_sel2", disp_sel, 2); chk("t4_dat2", disp_data, RDC);
    press(3); chk("t4_sel3", disp_sel, 3); chk("t4_dat3", disp_data, 32'h0BAD_F00D);
    press(3); chk("t4_sel4", disp_sel, 4); chk("t4_dat4", disp_data, 0);
    press(3); chk("t4_sel0", disp_sel, 0); chk("t4_dat0", disp_data, RDA);
    press(3); chk("t4_sel1b", disp_sel, 1); chk("t4_dat1b", disp_data, RDB);
    sw = 32'h8002_0C41;
    press(0);
    chk("t5_phase1", phase, 1);
    btn[1] = 1'b0;
    tick(10);
    chk("t5_disarm", phase, 0);
    press(0);
    chk("t5_ign_phase", phase, 0);
    chk("t5_no_wr", wr_cnt, 1);
    btn[1] = 1'b1;
    tick(10);
    sw = 32'h0000_7FFF;
    btn[0] = 1'b1;
    btn[2] = 1'b1;
    tick(10);
    btn[0] = 1'b0;
    btn[2] = 1'b0;
    tick(10);
    chk("t5_clr_cnt", clr_cnt, 1);
    chk("t5_clr_phase", phase, 0);
    chk("t5_clr_addr", rf.R_Addr_A, 1);
    chk("t5_clr_sel", disp_sel, 1);
    chk("t5_clr_wr", wr_cnt, 1);
    sw = 32'h8002_0C41;
    press(0);
    sw = 32'hCAFE_0001;
    btn[0] = 1'b1;
    k = 0;
    do begin tick(1); k++; end while (!rf.Write_Reg && k < 30);
    chk("t6_commit", rf.Write_Reg, 1);
    clr_n = 1'b0;
    #1;
    chk("t6_wr_drop", rf.Write_Reg, 0);
    chk("t6_phase", phase, 0);
    chk("t6_addr", {rf.R_Addr_A, rf.R_Addr_B, rf.R_Addr_C, rf.W_Addr}, 0);
    chk("t6_wdata", rf.W_Data, 0);
    chk("t6_disp", {disp_sel, disp_data[28:0]}, 0);
    btn = '0;
    tick(2);
    clr_n = 1'b1;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
